glip_downscale_arb: RTL

Round-robin arbiter and sequencer that shares one narrow FIFO output channel between CHANNELS wide (2×OUT_SIZE) input FIFO streams. Each granted input word is emitted atomically as two output transfers, upper half first, then lower half, with the source channel index alongside. It sits between several on-chip producers, such as debug/trace sources, and a single narrow GLIP link, replacing per-source downscalers plus a separate mux.

---
 rtl/glip_downscale_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/glip_downscale_arb.sv
// glip_downscale_arb: round-robin arbiter + 2:1 downscaler.
// CHANNELS wide (2*OUT_SIZE) input streams share one OUT_SIZE output; each
// granted word leaves as two transfers (upper half, then lower half) with
// its source channel alongside.
// Optional build macro: GLIP_DOWNSCALE_ARB_HEADER_EN -- prefixes every word
// with a header transfer carrying the channel index.
module glip_downscale_arb #(
  parameter  int OUT_SIZE = 16,
  parameter  int CHANNELS = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*2*OUT_SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [OUT_SIZE-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CW-1:0]                  out_channel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPPER = 2'd1,
    LOWER = 2'd2
`ifdef GLIP_DOWNSCALE_ARB_HEADER_EN
    , HEADER = 2'd3
`endif
  } state_e;

  // State entered right after a grant is made.
`ifdef GLIP_DOWNSCALE_ARB_HEADER_EN
  localparam state_e FIRST = HEADER;
`else
  localparam state_e FIRST = UPPER;
`endif

  state_e                            state_q;
  logic [CW-1:0]                     grant_q;
  logic [CW-1:0]                     ptr_q;
  logic [OUT_SIZE-1:0]               lower_q;

  logic [CHANNELS-1:0][2*OUT_SIZE-1:0] words;
  logic [CW-1:0]                     ptr_d;
  logic [CW:0]                       arb_idle;
  logic [CW:0]                       arb_next;

  assign words = in_data;

  // Round-robin search starting at base; returns {found, index}.
  // Walking offsets high-to-low lets the lowest offset overwrite last.
  function automatic logic [CW:0] pick(input logic [CHANNELS-1:0] v,
                                       input logic [CW-1:0]       base);
    logic [CW:0] r;
    int          idx;
    r = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % CHANNELS;
      if (v[idx]) r = {1'b1, idx[CW-1:0]};
    end
    return r;
  endfunction

  // Pointer after finishing the current word; wraps for any CHANNELS.
  assign ptr_d    = (grant_q == CW'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
  assign arb_idle = pick(in_valid, ptr_q);
  // LOWER re-arbitrates in the same cycle using the advanced pointer.
  assign arb_next = pick(in_valid, ptr_d);

  // Sequencer: grant, emit upper half, emit buffered lower half, re-arbitrate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_idle[CW]) begin
            grant_q <= arb_idle[CW-1:0];
            state_q <= FIRST;
          end
        end
`ifdef GLIP_DOWNSCALE_ARB_HEADER_EN
        HEADER: begin
          if (out_ready) state_q <= UPPER;
        end
`endif
        UPPER: begin
          // Lower half is captured so the producer is released after one beat.
          if (in_valid[grant_q] && out_ready) begin
            lower_q <= words[grant_q][OUT_SIZE-1:0];
            state_q <= LOWER;
          end
        end
        LOWER: begin
          if (out_ready) begin
            ptr_q <= ptr_d;
            if (arb_next[CW]) begin
              grant_q <= arb_next[CW-1:0];
              state_q <= FIRST;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output steering from the current state; UPPER passes the producer through.
  always_comb begin
    out_data    = '0;
    out_valid   = 1'b0;
    in_ready    = '0;
    out_channel = '0;
    case (state_q)
      UPPER: begin
        out_data          = words[grant_q][2*OUT_SIZE-1:OUT_SIZE];
        out_valid         = in_valid[grant_q];
        in_ready[grant_q] = out_ready;
        out_channel       = grant_q;
      end
      LOWER: begin
        out_data    = lower_q;
        out_valid   = 1'b1;
        out_channel = grant_q;
      end
`ifdef GLIP_DOWNSCALE_ARB_HEADER_EN
      HEADER: begin
        out_data    = OUT_SIZE'(grant_q);
        out_valid   = 1'b1;
        out_channel = grant_q;
      end
`endif
      default: ;
    endcase
  end

endmodule
